// File: rtl/sseg_scan_driver.sv
// Time-multiplexed hex driver for an N-digit seven-segment display, with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan_driver #(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int GUARD         = 2,
    parameter int DIGIT_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    output logic [DIGITS-1:0]     digit,
    output logic [7:0]            out,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIG_OFF  = (DIGIT_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Scan position
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cnt_wrap;
    logic          idx_wrap;
    logic          boundary;

    // Pending (host-side) buffer
    logic [4*DIGITS-1:0] pend_value_q, pend_value_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                pend_valid_q, pend_valid_d;

    // Shadow (displayed) buffer
    logic [4*DIGITS-1:0] sh_value_q, sh_value_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;

    // Registered outputs
    logic [DIGITS-1:0] digit_q, digit_d;
    logic [7:0]        out_q, out_d;
    logic              frame_done_q, frame_done_d;

    // Current-slot decode
    logic [DIGITS-1:0] lzb;
    logic [DIGITS-1:0] slot_onehot;
    logic [3:0]        slot_nib;
    logic              slot_dp;
    logic              slot_blank;
    logic [6:0]        slot_seg;
    logic              in_guard;

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        idx_wrap = (idx_q == IDX_LAST);
        boundary = cnt_wrap && idx_wrap;

        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        end
    end

    // load is a single-cycle strobe with no back-pressure: the last strobe before a
    // frame boundary wins, and a strobe on the boundary cycle itself bypasses pending.
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        sh_value_d   = sh_value_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;

        if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_valid_d = 1'b1;
        end

        if (boundary) begin
            pend_valid_d = 1'b0;
            if (load) begin
                sh_value_d = value;
                sh_dp_d    = dp_in;
                sh_blank_d = blank_in;
            end else if (pend_valid_q) begin
                sh_value_d = pend_value_q;
                sh_dp_d    = pend_dp_q;
                sh_blank_d = pend_blank_q;
            end
        end

        frame_done_d = boundary;
    end

`ifdef SSEG_LZB_EN
    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        logic zero_run;
        lzb      = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (sh_value_q[4*k +: 4] == 4'h0);
            lzb[k]   = zero_run;
        end
    end
`else
    assign lzb = '0;
`endif

    always_comb begin
        slot_nib    = 4'h0;
        slot_dp     = 1'b0;
        slot_blank  = 1'b0;
        slot_onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                slot_nib       = sh_value_q[4*k +: 4];
                slot_dp        = sh_dp_q[k];
                slot_blank     = sh_blank_q[k] | lzb[k];
                slot_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        case (slot_nib)
            4'h0:    slot_seg = 7'h3F;
            4'h1:    slot_seg = 7'h06;
            4'h2:    slot_seg = 7'h5B;
            4'h3:    slot_seg = 7'h4F;
            4'h4:    slot_seg = 7'h66;
            4'h5:    slot_seg = 7'h6D;
            4'h6:    slot_seg = 7'h7D;
            4'h7:    slot_seg = 7'h07;
            4'h8:    slot_seg = 7'h7F;
            4'h9:    slot_seg = 7'h6F;
            4'hA:    slot_seg = 7'h77;
            4'hB:    slot_seg = 7'h7C;
            4'hC:    slot_seg = 7'h58;
            4'hD:    slot_seg = 7'h5E;
            4'hE:    slot_seg = 7'h79;
            default: slot_seg = 7'h71;
        endcase
    end

    // The first GUARD cycles of each slot keep every digit dark to hide segment ghosting.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt_q < CW'(GUARD));
        end
    endgenerate

    always_comb begin
        digit_d = DIG_OFF;
        out_d   = 8'h00;
        if (!in_guard) begin
            digit_d = (DIGIT_ACT_LOW != 0) ? ~slot_onehot : slot_onehot;
            out_d   = slot_blank ? 8'h00 : {slot_dp, slot_seg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            sh_value_q   <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= {DIGITS{1'b1}};
            digit_q      <= DIG_OFF;
            out_q        <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            sh_value_q   <= sh_value_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            digit_q      <= digit_d;
            out_q        <= out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit      = digit_q;
    assign out        = out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: 4-digit active-low instance plus a 1-digit active-high instance.
// Expected segment bytes per frame are hand-decoded; define SSEG_LZB_EN to match a blanking build.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [3:0]  digit;
    logic [7:0]  out;
    logic        frame_done;

    logic [3:0]  value1;
    logic [0:0]  dp_in1;
    logic [0:0]  blank_in1;
    logic        load1;
    logic [0:0]  digit1;
    logic [7:0]  out1;
    logic        frame_done1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .GUARD(1), .DIGIT_ACT_LOW(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .digit(digit), .out(out), .frame_done(frame_done)
    );

    sseg_scan_driver #(
        .DIGITS(1), .SCAN_DIV(2), .GUARD(0), .DIGIT_ACT_LOW(0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .value(value1), .dp_in(dp_in1), .blank_in(blank_in1),
        .load(load1), .digit(digit1), .out(out1), .frame_done(frame_done1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One frame (or its first n_slots cycles). exp_seg = {d3,d2,d1,d0} segment bytes shown
    // this frame. Loads are strobed on cycle offsets ld_a / ld_b (-1 = none).
    task automatic run_frame(input string name, input logic [31:0] exp_seg, input int n_slots,
                             input int ld_a, input logic [15:0] val_a,
                             input int ld_b, input logic [15:0] val_b,
                             input logic [3:0] dp, input logic [3:0] blk);
        for (int j = 0; j < n_slots; j++) begin
            int         c;
            int         i;
            logic [3:0] exp_dig;
            logic [7:0] exp_out;
            load     = (j == ld_a) || (j == ld_b);
            value    = (j == ld_b) ? val_b : val_a;
            dp_in    = dp;
            blank_in = blk;
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            c = j % 4;
            i = j / 4;
            if (c < 1) begin
                exp_dig = 4'hF;
                exp_out = 8'h00;
            end else begin
                exp_dig = ~(4'b0001 << i);
                exp_out = exp_seg[8*i +: 8];
            end
            check({name, " digit"}, {4'h0, digit}, {4'h0, exp_dig});
            check({name, " out"}, out, exp_out);
            check({name, " frame_done"}, {7'h0, frame_done}, {7'h0, (j == 15)});
            check({name, " d1 digit"}, {7'h0, digit1}, 8'h01);
            check({name, " d1 out"}, out1, 8'h00);
            check({name, " d1 frame_done"}, {7'h0, frame_done1}, {7'h0, (j % 2 == 1)});
        end
    endtask

    task automatic check_reset(input string name);
        check({name, " digit"}, {4'h0, digit}, 8'h0F);
        check({name, " out"}, out, 8'h00);
        check({name, " frame_done"}, {7'h0, frame_done}, 8'h00);
        check({name, " d1 digit"}, {7'h0, digit1}, 8'h00);
        check({name, " d1 out"}, out1, 8'h00);
    endtask

    initial begin
        rst_n     = 1'b1;
        value     = 16'h0;
        dp_in     = 4'h0;
        blank_in  = 4'h0;
        load      = 1'b0;
        value1    = 4'h0;
        dp_in1    = 1'b0;
        blank_in1 = 1'b0;
        load1     = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Blank shadow after reset; frame_done every 16 cycles.
        run_frame("f0_idle",     32'h00000000, 16, -1, 16'h0,    -1, 16'h0,    4'b0000, 4'b0000);
        run_frame("f1_load_mid", 32'h00000000, 16,  5, 16'h12AB, -1, 16'h0,    4'b0100, 4'b0000);
        // 12AB with dp on digit 2: B=7C A=77 2+dp=DB 1=06.
        run_frame("f2_12ab",     32'h06DB777C, 16,  3, 16'h1111,  9, 16'h2222, 4'b0000, 4'b0000);
        // Second load wins; BEEF strobed on the boundary cycle.
        run_frame("f3_2222",     32'h5B5B5B5B, 16, 15, 16'hBEEF, -1, 16'h0,    4'b0000, 4'b0000);
        run_frame("f4_beef",     32'h7C797971, 16,  7, 16'h0050, -1, 16'h0,    4'b0000, 4'b0000);
`ifdef SSEG_LZB_EN
        run_frame("f5_0050",     32'h00006D3F, 16,  2, 16'h0000, -1, 16'h0,    4'b1111, 4'b0000);
        run_frame("f6_0000",     32'h000000BF, 16,  4, 16'h9876, -1, 16'h0,    4'b0001, 4'b0101);
`else
        run_frame("f5_0050",     32'h3F3F6D3F, 16,  2, 16'h0000, -1, 16'h0,    4'b1111, 4'b0000);
        run_frame("f6_0000",     32'hBFBFBFBF, 16,  4, 16'h9876, -1, 16'h0,    4'b0001, 4'b0101);
`endif
        // 9876 with digits 0 and 2 forced blank (dp of digit 0 also dark).
        run_frame("f7_9876",     32'h6F000700, 16, 10, 16'hCD34, -1, 16'h0,    4'b0000, 4'b0000);
        // Stop with digit 2 active; a load is left pending.
        run_frame("f8_cd34",     32'h585E4F66, 10,  3, 16'h5555, -1, 16'h0,    4'b0000, 4'b0000);

        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_reset("held_reset");
        rst_n = 1'b1;

        run_frame("f9_after_rst",     32'h00000000, 16, -1, 16'h0,    -1, 16'h0, 4'b0000, 4'b0000);
        run_frame("f10_pend_cleared", 32'h00000000, 16, 15, 16'hA5F0, -1, 16'h0, 4'b0000, 4'b0000);
        run_frame("f11_a5f0",         32'h776D713F, 16, -1, 16'h0,    -1, 16'h0, 4'b0000, 4'b0000);

        // Single-digit instance: every slot end is a frame boundary.
        load1  = 1'b1;
        value1 = 4'h7;
        dp_in1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load1 = 1'b0;
        check("d1 pending out", out1, 8'h00);
        check("d1 pending frame_done", {7'h0, frame_done1}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("d1 boundary out", out1, 8'h00);
        check("d1 boundary frame_done", {7'h0, frame_done1}, 8'h01);
        @(posedge clk);
        @(negedge clk);
        check("d1 shown out", out1, 8'h87);
        check("d1 shown digit", {7'h0, digit1}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
